round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, max consecutive grant cycles while another requester waits (legal 1..255).
REQ-002 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Req  input  16  request lines; bit i (weight 2^i) = requester i.
REQ-005 SHALL have port Grant  output  16  registered one-hot grant (or all-zero); feeds the 16-to-4 encoder directly.
REQ-006 SHALL have port Busy  output  1  high while in GRANT state.
REQ-007 SHALL have port Preempt  output  1  one-cycle pulse when a grant ends by HOLD_MAX expiry.

Function
REQ-008 SHALL serve requesters 0..14 only; Req bit 15 ignored, Grant bit 15 constant 0 (downstream encodes bit 15 as "none").
REQ-009 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-010 SHALL in IDLE, on any valid Req, select winner and enter GRANT next edge; Grant one-hot on the winner from that edge (1-cycle latency Req->Grant).
REQ-011 SHALL select winner round-robin: first set Req bit at or above pointer Ptr (4-bit, 0..14), wrapping 14->0.
REQ-012 SHALL in GRANT hold Grant stable while owner's Req stays high and hold counter < HOLD_MAX, or while no other valid Req is set (counter saturates at HOLD_MAX).
REQ-013 SHALL leave GRANT to GAP when owner's Req drops (normal release) or counter == HOLD_MAX with another valid Req set (preempt, Preempt pulses on that edge).
REQ-014 SHALL on leaving GRANT set Ptr = owner+1, wrapping 15->0 (i.e. owner 14 -> Ptr 0).
REQ-015 SHALL in GAP drive Grant = 0 for exactly one cycle, then arbitrate: GRANT if any valid Req, else IDLE.
REQ-016 SHALL count hold cycles in an 8-bit counter: 1 on the first GRANT cycle, +1 per cycle, cleared on entry to GAP.
REQ-017 SHALL never assert more than one Grant bit; Grant is 0 in IDLE and GAP.
REQ-018 SHALL treat simultaneous owner release and HOLD_MAX expiry as normal release (no Preempt).
REQ-019 SHALL re-grant a preempted requester only after all other pending requesters above it in round-robin order.

Reset
REQ-020 SHALL on Rst asynchronously force state IDLE, Grant 0, Busy 0, Preempt 0, Ptr 0, counter 0.
REQ-021 SHALL when Rst asserts mid-grant drop Grant immediately (no GAP cycle); first grant after release follows REQ-010.

Structure
REQ-022 SHALL keep FSM state encoding, NUM_REQ = 15 and the pointer width in a shared package used by encoder-side testbenches.
REQ-023 SHALL use one sub-module, rr_pick, combinational: Req[14:0] + Ptr -> one-hot winner + index.
REQ-024 SHALL keep all outputs registered; no combinational path Req->Grant.

Verification
REQ-025 SHALL cover single request: Req=0x0008 from IDLE -> Grant=0x0008, Busy=1 next cycle; drop Req -> one GAP cycle Grant=0, then IDLE.
REQ-026 SHALL cover rotation: Req=0x0005 held, owners release after 2 cycles -> grants 0x0001, 0x0004, 0x0001, each separated by one zero cycle.
REQ-027 SHALL cover preemption: HOLD_MAX=8, Req=0x0003 held -> bit0 granted 8 cycles, Preempt pulse, GAP, then Grant=0x0002.
REQ-028 SHALL cover bit 15 and wrap: Req=0xC000 -> Grant=0x4000 only; after release Ptr=0, Req=0x4001 -> Grant=0x0001 first.
REQ-029 SHALL cover reset mid-grant: Grant=0x0010, assert Rst asynchronously -> Grant=0, Busy=0 before next edge; release with Req=0x0010 -> Grant=0x0010 one cycle later.
REQ-030 SHALL check with assertions every cycle: Grant one-hot-or-zero, Grant[15]=0, Preempt only on GRANT->GAP.

Source files
------------

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: requester count,
// pointer width and FSM state encoding.
package round_robin_arbiter_pkg;

  localparam int NUM_REQ = 15;
  localparam int PTR_W   = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Pointer position just after a given owner, wrapping past the last
  // real requester back to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] owner);
    if (owner == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return owner + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from the last requester back to 0.
module rr_pick
  import round_robin_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

  // Requester index visited at each search offset from the pointer.
  logic [PTR_W-1:0] rot_idx [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      assign sum = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign rot_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ))
                           ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                           : sum[PTR_W-1:0];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[rot_idx[off]]) begin
        win_idx   = rot_idx[off];
        win_valid = 1'b1;
      end
    end
    win_onehot = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for requesters 0..14 with a bounded hold time.
// Bit 15 of Grant is reserved as "none" for the downstream encoder.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Req,
  output logic [15:0] Grant,
  output logic        Busy,
  output logic        Preempt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t             state_q, state_d;
  logic [15:0]        grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] valid_req;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               owner_req;
  logic               others_req;
  logic               req15_unused;

  // Bit 15 is not a requester; kept only so the port is fully consumed.
  assign req15_unused = Req[15];
  assign valid_req    = Req[NUM_REQ-1:0];
  assign owner_req    = |(valid_req & grant_q[NUM_REQ-1:0]);
  assign others_req   = |(valid_req & ~grant_q[NUM_REQ-1:0]);

  rr_pick u_pick (
    .req        (valid_req),
    .ptr        (ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Next-state and registered-output logic for IDLE / GRANT / GAP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (state_q == ST_GAP) begin
          state_d = ST_IDLE;
        end
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = {1'b0, pick_onehot};
          busy_d  = 1'b1;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // Owner release takes priority over expiry: no Preempt then.
        if (!owner_req || (cnt_q == HOLD_LIM && others_req)) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          ptr_d     = next_ptr(owner_q);
          preempt_d = owner_req;
        end else if (cnt_q != HOLD_LIM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset drops the grant immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Grant   = grant_q;
  assign Busy    = busy_q;
  assign Preempt = preempt_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with per-cycle invariant checks.
module tb_round_robin_arbiter;

  logic        Clk;
  logic        Rst;
  logic [15:0] Req;
  logic [15:0] Grant;
  logic        Busy;
  logic        Preempt;

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_busy = 1'b0;

  round_robin_arbiter #(.HOLD_MAX(8)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Req     (Req),
    .Grant   (Grant),
    .Busy    (Busy),
    .Preempt (Preempt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
    $display("t=%0t Req=0x%04h Grant=0x%04h Busy=%0b Preempt=%0b", $time, Req, Grant, Busy, Preempt);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] g, input logic b, input logic p);
    check_eq({tag, ".grant"}, Grant, g);
    check_eq({tag, ".busy"}, {15'b0, Busy}, {15'b0, b});
    check_eq({tag, ".preempt"}, {15'b0, Preempt}, {15'b0, p});
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Every-cycle invariants: one-hot-or-zero, bit 15 clear, Preempt only on GRANT->GAP.
  always @(negedge Clk) begin
    if (Rst) begin
      prev_busy = 1'b0;
    end else begin
      check_eq("inv_onehot", {15'b0, $onehot0(Grant)}, 16'h0001);
      check_eq("inv_bit15", {15'b0, Grant[15]}, 16'h0000);
      check_eq("inv_preempt", {15'b0, Preempt & ~(prev_busy & ~Busy)}, 16'h0000);
      prev_busy = Busy;
    end
  end

  initial begin
    Rst = 1'b1;
    Req = 16'h0000;
    #2;
    expect_out("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    step();
    expect_out("idle", 16'h0000, 1'b0, 1'b0);

    // Single request, release, one GAP cycle, back to IDLE (Ptr ends at 4).
    Req = 16'h0008; step(); expect_out("single.grant", 16'h0008, 1'b1, 1'b0);
    Req = 16'h0000; step(); expect_out("single.gap", 16'h0000, 1'b0, 1'b0);
    step();                 expect_out("single.idle", 16'h0000, 1'b0, 1'b0);

    // Rotation between bits 0 and 2, each owner holding two cycles.
    Req = 16'h0005; step(); check_eq("rot.a1", Grant, 16'h0001);
    step();                 check_eq("rot.a2", Grant, 16'h0001);
    Req = 16'h0004; step(); check_eq("rot.gap1", Grant, 16'h0000);
    Req = 16'h0005; step(); check_eq("rot.b1", Grant, 16'h0004);
    step();                 check_eq("rot.b2", Grant, 16'h0004);
    Req = 16'h0001; step(); check_eq("rot.gap2", Grant, 16'h0000);
    Req = 16'h0005; step(); check_eq("rot.c1", Grant, 16'h0001);
    Req = 16'h0000; step(); check_eq("rot.gap3", Grant, 16'h0000);
    step();                 expect_out("rot.idle", 16'h0000, 1'b0, 1'b0);

    // Preemption after 8 cycles, then back again, then saturation.
    do_reset();
    Req = 16'h0003;
    for (int i = 0; i < 8; i++) begin
      step(); expect_out("pre.hold0", 16'h0001, 1'b1, 1'b0);
    end
    step(); expect_out("pre.gap0", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(); expect_out("pre.hold1", 16'h0002, 1'b1, 1'b0);
    end
    step(); expect_out("pre.gap1", 16'h0000, 1'b0, 1'b1);
    step(); expect_out("pre.back0", 16'h0001, 1'b1, 1'b0);
    Req = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      step(); expect_out("sat.hold", 16'h0001, 1'b1, 1'b0);
    end
    Req = 16'h0003; step(); expect_out("sat.preempt", 16'h0000, 1'b0, 1'b1);
    Req = 16'h0000; step(); expect_out("sat.idle", 16'h0000, 1'b0, 1'b0);

    // Owner release coinciding with expiry is a normal release.
    do_reset();
    Req = 16'h0003;
    for (int i = 0; i < 8; i++) begin
      step(); check_eq("tie.hold", Grant, 16'h0001);
    end
    Req = 16'h0002; step(); expect_out("tie.gap", 16'h0000, 1'b0, 1'b0);
    step();                 expect_out("tie.next", 16'h0002, 1'b1, 1'b0);
    Req = 16'h0000; step(); step();

    // Bit 15 ignored; owner 14 wraps the pointer to 0.
    Req = 16'hC000; step(); expect_out("wrap.g14", 16'h4000, 1'b1, 1'b0);
    Req = 16'h0000; step(); check_eq("wrap.gap", Grant, 16'h0000);
    step();                 check_eq("wrap.idle", Grant, 16'h0000);
    Req = 16'h4001; step(); check_eq("wrap.g0", Grant, 16'h0001);
    Req = 16'h8000; step(); check_eq("wrap.gap2", Grant, 16'h0000);
    step();                 expect_out("wrap.b15only", 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-grant.
    Req = 16'h0010; step(); check_eq("rst.grant", Grant, 16'h0010);
    #2 Rst = 1'b1;
    #1 expect_out("rst.async", 16'h0000, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    step(); expect_out("rst.regrant", 16'h0010, 1'b1, 1'b0);
    Req = 16'h0000; step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
